pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Backward-direction control for the 5-stage RISC-V pipeline.
- id_ex carries data forward from ID to EX; pipe_ctrl carries decisions from EX/ID back to the PC, if_id and id_ex registers.
- It turns jump requests, multi-cycle EX busy and load-use hazards into hold/flush/redirect controls. A small FSM stretches flushes across the fetch latency.
- It also keeps stall and flush performance counters.

Parameters:
- FETCH_LAT, 1: extra cycles flush_if_id stays asserted after a jump, to squash in-flight fetches (0..7).
- NOP_INS, 32'h13: bubble instruction value, exported for the pipeline registers' flush path.
- CNT_W, 32: performance counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- jump_en  in  1  EX resolved a taken branch/jump this cycle.
- jump_addr  in  32  target address.
- ex_busy  in  1  multi-cycle EX operation not yet complete.
- ex_is_load  in  1  instruction in EX is a load.
- ex_rd_addr  in  5  EX destination register.
- ex_rd_wen  in  1  EX writes rd.
- id_rs1_addr  in  5  ID source register 1.
- id_rs2_addr  in  5  ID source register 2.
- id_rs1_ren  in  1  ID reads rs1.
- id_rs2_ren  in  1  ID reads rs2.
- hold_pc  out  1  freeze PC.
- hold_if_id  out  1  freeze if_id.
- hold_id_ex  out  1  freeze id_ex.
- flush_if_id  out  1  load NOP_INS into if_id.
- flush_id_ex  out  1  load NOP_INS / zeros into id_ex.
- redirect_en  out  1  PC loads redirect_addr.
- redirect_addr  out  32  jump target.
- stall_cnt  out  CNT_W  cycles with hold_pc=1.
- flush_cnt  out  CNT_W  jumps taken.

Behaviour:
- Reset (rst=0, async):
  - state=RUN, flush counter=0, stall_cnt=0, flush_cnt=0.
  - All control outputs=0, redirect_addr=0.
  - Reset mid-flush or mid-hold abandons the operation immediately.
- Load-use hazard, combinational: lu = ex_is_load & ex_rd_wen & ex_rd_addr!=0 & ((id_rs1_ren & id_rs1_addr==ex_rd_addr) | (id_rs2_ren & id_rs2_addr==ex_rd_addr)).
- Priority each cycle: jump_en > ex_busy > FLUSH state > lu.
- jump_en=1, in any state:
  - Same cycle: redirect_en=1, redirect_addr=jump_addr, flush_if_id=1, flush_id_ex=1. All holds=0.
  - flush_cnt+1.
  - If FETCH_LAT>0: next state=FLUSH with counter=FETCH_LAT. Otherwise next state=RUN.
  - A jump arriving during FLUSH restarts the counter at FETCH_LAT.
- ex_busy=1, no jump:
  - hold_pc=hold_if_id=hold_id_ex=1; flushes=0; redirect_en=0.
  - State FLUSH is paused: the counter does not decrement.
  - lu is ignored while busy.
- FLUSH state, no jump, no busy:
  - flush_if_id=1, flush_id_ex=0, holds=0.
  - Counter decrements; when it reaches 1 the next state is RUN.
- RUN with lu=1, no jump, no busy:
  - hold_pc=hold_if_id=1, flush_id_ex=1 (one bubble). Cleared automatically the next cycle as the load advances.
- RUN otherwise: all controls 0.
- stall_cnt increments on every cycle with hold_pc=1; flush_cnt increments per jump. Both wrap modulo 2^CNT_W.
- redirect_addr is combinational from jump_addr when redirect_en=1, else 0.
- Latency: all controls are combinational from inputs plus registered state, with zero-cycle response; counters update at the next edge.

Decomposition:
- Shared core package (riscv_defs):
  - NOP_INS (32'h13).
  - Register-address width 5.
  - FSM state encoding RUN=0, FLUSH=1.
- Sub-module hazard_det: pure combinational lu compare, reusable for forwarding checks.
- FSM, flush counter and perf counters stay in pipe_ctrl.

Test Plan:
- Reset: hold rst=0 with jump_en=1 -> all outputs 0, counters 0. Release -> state RUN.
- Jump, FETCH_LAT=1: jump_en=1, jump_addr=32'h0000_0040 for one cycle.
  - That cycle: redirect_en=1, redirect_addr=32'h40, both flushes=1.
  - Next cycle: flush_if_id=1 only.
  - Then all 0; flush_cnt=1.
- Load-use: ex_is_load=1, ex_rd_wen=1, ex_rd_addr=5, id_rs2_addr=5, id_rs2_ren=1 -> hold_pc=hold_if_id=flush_id_ex=1.
  - Same case with ex_rd_addr=0 -> no stall.
- Busy: ex_busy=1 for 4 cycles -> all three holds=1 for exactly 4 cycles; stall_cnt=4.
- Jump during busy, then jump during FLUSH:
  - Jump during busy: jump wins, holds=0, redirect=1.
  - Second jump one cycle after the first: FLUSH counter restarts; flush_cnt=2.
- Counter wrap: CNT_W=4, 17 stall cycles -> stall_cnt=1.

Source files
------------

// File: rtl/riscv_defs.sv
// riscv_defs: shared pipeline constants (bubble instruction, register-address width) and pipe_ctrl FSM encoding
package riscv_defs;
  localparam logic [31:0] NOP_INS = 32'h13;
  localparam int REG_AW = 5;
  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;
endpackage

// File: rtl/hazard_det.sv
// hazard_det: combinational load-use compare; ports: EX rd/wen/is_load, ID rs1/rs2 addr+ren in, lu out
import riscv_defs::*;
module hazard_det (
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_rd_addr,
  input  logic              ex_rd_wen,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic              id_rs1_ren,
  input  logic              id_rs2_ren,
  output logic              lu
);
  assign lu = ex_is_load && ex_rd_wen && ex_rd_addr != '0 &&
              ((id_rs1_ren && id_rs1_addr == ex_rd_addr) || (id_rs2_ren && id_rs2_addr == ex_rd_addr));
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hold/flush/redirect control; ports: jump/busy/hazard inputs in, holds/flushes/redirect and stall/flush counters out
import riscv_defs::*;
module pipe_ctrl #(
  parameter int          FETCH_LAT = 1,
  parameter logic [31:0] NOP_INS   = riscv_defs::NOP_INS,
  parameter int          CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_en,
  input  logic [31:0]       jump_addr,
  input  logic              ex_busy,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_rd_addr,
  input  logic              ex_rd_wen,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic              id_rs1_ren,
  input  logic              id_rs2_ren,
  output logic              hold_pc,
  output logic              hold_if_id,
  output logic              hold_id_ex,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              redirect_en,
  output logic [31:0]       redirect_addr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  state_t     state, nxt_state;
  logic [2:0] fcnt, nxt_fcnt;
  logic       lu, jmp, busy;
  hazard_det u_hd (
    .ex_is_load (ex_is_load),
    .ex_rd_addr (ex_rd_addr),
    .ex_rd_wen  (ex_rd_wen),
    .id_rs1_addr(id_rs1_addr),
    .id_rs2_addr(id_rs2_addr),
    .id_rs1_ren (id_rs1_ren),
    .id_rs2_ren (id_rs2_ren),
    .lu         (lu)
  );
  // outputs are combinational, so gate requests with rst to keep them quiet while in reset
  assign jmp  = rst && jump_en;
  assign busy = rst && ex_busy;
  always_comb begin
    nxt_state     = state;
    nxt_fcnt      = fcnt;
    hold_pc       = 1'b0;
    hold_if_id    = 1'b0;
    hold_id_ex    = 1'b0;
    flush_if_id   = 1'b0;
    flush_id_ex   = 1'b0;
    redirect_en   = 1'b0;
    redirect_addr = '0;
    if (jmp) begin
      redirect_en   = 1'b1;
      redirect_addr = jump_addr;
      flush_if_id   = 1'b1;
      flush_id_ex   = 1'b1;
      nxt_state     = FETCH_LAT > 0 ? FLUSH : RUN;
      nxt_fcnt      = 3'(FETCH_LAT);
    end else if (busy) begin
      hold_pc    = 1'b1;
      hold_if_id = 1'b1;
      hold_id_ex = 1'b1;
    end else if (state == FLUSH) begin
      flush_if_id = 1'b1;
      nxt_fcnt    = fcnt - 3'd1;
      nxt_state   = fcnt <= 3'd1 ? RUN : FLUSH;
    end else if (rst && lu) begin
      hold_pc     = 1'b1;
      hold_if_id  = 1'b1;
      flush_id_ex = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      fcnt      <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state     <= nxt_state;
      fcnt      <= nxt_fcnt;
      stall_cnt <= stall_cnt + CNT_W'(hold_pc);
      flush_cnt <= flush_cnt + CNT_W'(jmp);
    end
  end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        ex_busy, ex_is_load, ex_rd_wen, id_rs1_ren, id_rs2_ren;
  logic [4:0]  ex_rd_addr, id_rs1_addr, id_rs2_addr;
  logic        hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex, redirect_en;
  logic [31:0] redirect_addr, stall_cnt, flush_cnt;
  logic        w_hold_pc, w_hold_if_id, w_hold_id_ex, w_flush_if_id, w_flush_id_ex, w_redirect_en;
  logic [31:0] w_redirect_addr;
  logic [3:0]  w_stall_cnt, w_flush_cnt;
  logic [5:0]  ctl;
  int          n_cmp = 0;
  int          n_bad = 0;
  assign ctl = {hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex, redirect_en};
  always #5 clk = ~clk;
  pipe_ctrl #(.FETCH_LAT(1), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .jump_en(jump_en), .jump_addr(jump_addr), .ex_busy(ex_busy),
    .ex_is_load(ex_is_load), .ex_rd_addr(ex_rd_addr), .ex_rd_wen(ex_rd_wen),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rs1_ren(id_rs1_ren), .id_rs2_ren(id_rs2_ren),
    .hold_pc(hold_pc), .hold_if_id(hold_if_id), .hold_id_ex(hold_id_ex), .flush_if_id(flush_if_id),
    .flush_id_ex(flush_id_ex), .redirect_en(redirect_en), .redirect_addr(redirect_addr),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  pipe_ctrl #(.FETCH_LAT(1), .CNT_W(4)) dut_w (
    .clk(clk), .rst(rst), .jump_en(jump_en), .jump_addr(jump_addr), .ex_busy(ex_busy),
    .ex_is_load(ex_is_load), .ex_rd_addr(ex_rd_addr), .ex_rd_wen(ex_rd_wen),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rs1_ren(id_rs1_ren), .id_rs2_ren(id_rs2_ren),
    .hold_pc(w_hold_pc), .hold_if_id(w_hold_if_id), .hold_id_ex(w_hold_id_ex), .flush_if_id(w_flush_if_id),
    .flush_id_ex(w_flush_id_ex), .redirect_en(w_redirect_en), .redirect_addr(w_redirect_addr),
    .stall_cnt(w_stall_cnt), .flush_cnt(w_flush_cnt)
  );
  task automatic idle();
    jump_en = 0; jump_addr = 0; ex_busy = 0; ex_is_load = 0; ex_rd_wen = 0; ex_rd_addr = 0;
    id_rs1_addr = 0; id_rs2_addr = 0; id_rs1_ren = 0; id_rs2_ren = 0;
  endtask
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic do_reset();
    idle(); rst = 0; tick(); tick(); rst = 1; #1;
  endtask
  task automatic test_reset();
    idle(); rst = 0; jump_en = 1; jump_addr = 32'h40; ex_busy = 1;
    tick(); tick(); #1;
    n_cmp++; if (ctl !== 6'b0 || redirect_addr !== 32'h0) begin n_bad++; $display("FAIL reset_out ctl=%b addr=%h exp 0/0", ctl, redirect_addr); end
    n_cmp++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_cnt stall=%0d flush=%0d exp 0/0", stall_cnt, flush_cnt); end
    idle(); rst = 1; #1;
    n_cmp++; if (ctl !== 6'b0) begin n_bad++; $display("FAIL reset_release ctl=%b exp 000000", ctl); end
    tick();
    n_cmp++; if (ctl !== 6'b0 || flush_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_run ctl=%b flush=%0d exp 000000/0", ctl, flush_cnt); end
  endtask
  task automatic test_jump();
    do_reset();
    jump_en = 1; jump_addr = 32'h0000_0040; #1;
    n_cmp++; if (ctl !== 6'b000111 || redirect_addr !== 32'h40) begin n_bad++; $display("FAIL jump_c0 ctl=%b addr=%h exp 000111/40", ctl, redirect_addr); end
    tick(); jump_en = 0; jump_addr = 32'hdead_beef; #1;
    n_cmp++; if (ctl !== 6'b000100 || redirect_addr !== 32'h0) begin n_bad++; $display("FAIL jump_c1 ctl=%b addr=%h exp 000100/0", ctl, redirect_addr); end
    tick();
    n_cmp++; if (ctl !== 6'b0) begin n_bad++; $display("FAIL jump_c2 ctl=%b exp 000000", ctl); end
    n_cmp++; if (flush_cnt !== 32'd1 || stall_cnt !== 32'd0) begin n_bad++; $display("FAIL jump_cnt flush=%0d stall=%0d exp 1/0", flush_cnt, stall_cnt); end
  endtask
  task automatic test_load_use();
    do_reset();
    ex_is_load = 1; ex_rd_wen = 1; ex_rd_addr = 5; id_rs2_addr = 5; id_rs2_ren = 1; #1;
    n_cmp++; if (ctl !== 6'b110010) begin n_bad++; $display("FAIL lu_rs2 ctl=%b exp 110010", ctl); end
    tick(); ex_rd_addr = 0; id_rs2_addr = 0; #1;
    n_cmp++; if (ctl !== 6'b0) begin n_bad++; $display("FAIL lu_x0 ctl=%b exp 000000", ctl); end
    n_cmp++; if (stall_cnt !== 32'd1) begin n_bad++; $display("FAIL lu_stall stall=%0d exp 1", stall_cnt); end
    ex_rd_addr = 9; id_rs1_addr = 9; id_rs1_ren = 0; id_rs2_addr = 3; #1;
    n_cmp++; if (ctl !== 6'b0) begin n_bad++; $display("FAIL lu_noren ctl=%b exp 000000", ctl); end
    id_rs1_ren = 1; #1;
    n_cmp++; if (ctl !== 6'b110010) begin n_bad++; $display("FAIL lu_rs1 ctl=%b exp 110010", ctl); end
    ex_is_load = 0; #1;
    n_cmp++; if (ctl !== 6'b0) begin n_bad++; $display("FAIL lu_noload ctl=%b exp 000000", ctl); end
    idle();
  endtask
  task automatic test_busy();
    do_reset();
    ex_busy = 1; ex_is_load = 1; ex_rd_wen = 1; ex_rd_addr = 7; id_rs1_addr = 7; id_rs1_ren = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (ctl !== 6'b111000) begin n_bad++; $display("FAIL busy_c%0d ctl=%b exp 111000", i, ctl); end
      tick();
    end
    idle(); #1;
    n_cmp++; if (ctl !== 6'b0) begin n_bad++; $display("FAIL busy_end ctl=%b exp 000000", ctl); end
    n_cmp++; if (stall_cnt !== 32'd4) begin n_bad++; $display("FAIL busy_stall stall=%0d exp 4", stall_cnt); end
  endtask
  task automatic test_jump_busy();
    do_reset();
    ex_busy = 1; jump_en = 1; jump_addr = 32'h100; #1;
    n_cmp++; if (ctl !== 6'b000111 || redirect_addr !== 32'h100) begin n_bad++; $display("FAIL jb_jump ctl=%b addr=%h exp 000111/100", ctl, redirect_addr); end
    tick(); jump_en = 0; #1;
    n_cmp++; if (ctl !== 6'b111000) begin n_bad++; $display("FAIL jb_pause ctl=%b exp 111000", ctl); end
    tick(); ex_busy = 0; #1;
    n_cmp++; if (ctl !== 6'b000100) begin n_bad++; $display("FAIL jb_resume ctl=%b exp 000100", ctl); end
    jump_en = 1; jump_addr = 32'h200; #1;
    n_cmp++; if (ctl !== 6'b000111 || redirect_addr !== 32'h200) begin n_bad++; $display("FAIL jb_jump2 ctl=%b addr=%h exp 000111/200", ctl, redirect_addr); end
    tick(); jump_en = 0; #1;
    n_cmp++; if (ctl !== 6'b000100) begin n_bad++; $display("FAIL jb_restart ctl=%b exp 000100", ctl); end
    tick();
    n_cmp++; if (ctl !== 6'b0) begin n_bad++; $display("FAIL jb_done ctl=%b exp 000000", ctl); end
    n_cmp++; if (flush_cnt !== 32'd2 || stall_cnt !== 32'd1) begin n_bad++; $display("FAIL jb_cnt flush=%0d stall=%0d exp 2/1", flush_cnt, stall_cnt); end
  endtask
  task automatic test_back_to_back();
    do_reset();
    jump_en = 1; jump_addr = 32'h80; tick();
    jump_addr = 32'hc0; #1;
    n_cmp++; if (ctl !== 6'b000111 || redirect_addr !== 32'hc0) begin n_bad++; $display("FAIL b2b_j2 ctl=%b addr=%h exp 000111/c0", ctl, redirect_addr); end
    tick(); jump_en = 0; #1;
    n_cmp++; if (ctl !== 6'b000100) begin n_bad++; $display("FAIL b2b_flush ctl=%b exp 000100", ctl); end
    ex_is_load = 1; ex_rd_wen = 1; ex_rd_addr = 4; id_rs2_addr = 4; id_rs2_ren = 1; #1;
    n_cmp++; if (ctl !== 6'b000100) begin n_bad++; $display("FAIL b2b_flush_lu ctl=%b exp 000100", ctl); end
    tick(); idle(); #1;
    n_cmp++; if (ctl !== 6'b0 || flush_cnt !== 32'd2) begin n_bad++; $display("FAIL b2b_done ctl=%b flush=%0d exp 000000/2", ctl, flush_cnt); end
  endtask
  task automatic test_wrap();
    do_reset();
    ex_busy = 1;
    repeat (17) @(posedge clk);
    #1; ex_busy = 0; #1;
    n_cmp++; if (w_stall_cnt !== 4'd1) begin n_bad++; $display("FAIL wrap_narrow stall=%0d exp 1", w_stall_cnt); end
    n_cmp++; if (stall_cnt !== 32'd17) begin n_bad++; $display("FAIL wrap_wide stall=%0d exp 17", stall_cnt); end
  endtask
  initial begin
    idle(); rst = 0;
    test_reset();
    test_jump();
    test_load_use();
    test_busy();
    test_jump_busy();
    test_back_to_back();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
